// File: rtl/verificador_pkg.sv
// Shared types, sizes and the expected-table slicer for the truth-table checker.
// Latency: n/a (types and constant functions only); backpressure: n/a.
package verificador_pkg;

  localparam int NVEC  = 16;
  localparam int N_IN  = 4;
  localparam int N_OUT = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    DONE
  } estado_t;

  // Expected {yo,ys,z} for input vector idx; slot i sits at bits [3*i+2:3*i].
  function automatic logic [N_OUT-1:0] exp_slice(input logic [NVEC*N_OUT-1:0] tabla,
                                                 input logic [N_IN-1:0]        idx);
    return tabla[N_OUT*int'(idx) +: N_OUT];
  endfunction

endpackage

// File: rtl/verificador_tabla_gen_vectores.sv
// Input-vector counter plus per-vector settle timer driving the block under check.
// Latency: vec updates one edge after load/step; backpressure: none, tick only reports expiry.
module gen_vectores
  import verificador_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  output logic [N_IN-1:0] vec,
  output logic            last,
  output logic            tick
);

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  logic [3:0] settle_cnt;

  // The timer free-runs down to zero and parks there, so the FSM only
  // has to look at tick while it is waiting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec        <= '0;
      settle_cnt <= '0;
    end else if (load) begin
      vec        <= '0;
      settle_cnt <= RELOAD;
    end else if (step) begin
      vec        <= vec + 1'b1;
      settle_cnt <= RELOAD;
    end else if (settle_cnt != 4'd0) begin
      settle_cnt <= settle_cnt - 4'd1;
    end
  end

  assign last = (vec == {N_IN{1'b1}});
  assign tick = (settle_cnt == 4'd0);

endmodule

// File: rtl/verificador_tabla.sv
// Sweeps all 16 input vectors of a 4-in/3-out block and checks outputs against EXP_TABLE.
// Latency: 16*(SETTLE+1) cycles from start to done; backpressure: start ignored while busy.
module verificador_tabla
  import verificador_pkg::*;
#(
  parameter int                        SETTLE    = 2,
  parameter logic [NVEC*N_OUT-1:0]     EXP_TABLE = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic       yo,
  input  logic       ys,
  input  logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_err_idx,
  output logic       mis_valid,
  output logic [2:0] mis_got
);

  estado_t          state_q, state_d;
  logic             load, step, last, tick;
  logic [N_IN-1:0]  vec;
  logic [N_OUT-1:0] got;
  logic             mismatch;

  logic             busy_d, done_d, pass_d, mis_valid_d;
  logic [4:0]       err_count_d;
  logic [3:0]       first_err_idx_d;
  logic [2:0]       mis_got_d;

  gen_vectores #(
    .SETTLE (SETTLE)
  ) u_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .vec   (vec),
    .last  (last),
    .tick  (tick)
  );

  // vec is itself a register, so the stimulus pins stay registered outputs.
  assign {a, b, c, d} = vec;

  assign got      = {yo, ys, z};
  assign mismatch = (got != exp_slice(EXP_TABLE, vec));

  always_comb begin
    state_d         = state_q;
    load            = 1'b0;
    step            = 1'b0;
    busy_d          = busy;
    done_d          = done;
    pass_d          = pass;
    err_count_d     = err_count;
    first_err_idx_d = first_err_idx;
    mis_valid_d     = 1'b0;
    mis_got_d       = mis_got;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load            = 1'b1;
          busy_d          = 1'b1;
          done_d          = 1'b0;
          pass_d          = 1'b0;
          err_count_d     = 5'd0;
          first_err_idx_d = 4'd0;
          state_d         = WAIT;
        end
      end
      WAIT: begin
        if (tick) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          err_count_d = err_count + 5'd1;
          mis_valid_d = 1'b1;
          mis_got_d   = got;
          if (err_count == 5'd0) begin
            first_err_idx_d = vec;
          end
        end
        // pass must account for a mismatch on the final vector too.
        if (last) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_d == 5'd0);
          state_d = DONE;
        end else begin
          step    = 1'b1;
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= 5'd0;
      first_err_idx <= 4'd0;
      mis_valid     <= 1'b0;
      mis_got       <= 3'd0;
    end else begin
      state_q       <= state_d;
      busy          <= busy_d;
      done          <= done_d;
      pass          <= pass_d;
      err_count     <= err_count_d;
      first_err_idx <= first_err_idx_d;
      mis_valid     <= mis_valid_d;
      mis_got       <= mis_got_d;
    end
  end

endmodule

// File: tb/tb_verificador_tabla.sv
// Directed bench: two checker instances (SETTLE=2 and SETTLE=1) driving a reference block yo=a&b, ys=c|d, z=a^d.
// Latency: n/a; backpressure: n/a.
module tb_verificador_tabla;

  function automatic logic [47:0] mk_tabla();
    logic [47:0] t;
    logic [3:0]  v;
    t = '0;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      t[3*i +: 3] = {v[3] & v[2], v[1] | v[0], v[3] ^ v[0]};
    end
    return t;
  endfunction

  localparam logic [47:0] TABLA = mk_tabla();

  logic       clk = 1'b0;
  logic       rst_n, start, force_z;
  logic       a, b, c, d, yo, ys, z;
  logic       busy, done, pass, mis_valid;
  logic [4:0] err_count;
  logic [3:0] first_err_idx;
  logic [2:0] mis_got;

  logic       rst_n_1, start_1;
  logic       a1, b1, c1, d1, yo1, ys1, z1;
  logic       busy1, done1, pass1, mis_valid1;
  logic [4:0] err_count1;
  logic [3:0] first_err_idx1;
  logic [2:0] mis_got1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign yo  = a & b;
  assign ys  = c | d;
  assign z   = force_z ? 1'b0 : (a ^ d);
  assign yo1 = a1 & b1;
  assign ys1 = c1 | d1;
  assign z1  = a1 ^ d1;

  verificador_tabla #(.SETTLE(2), .EXP_TABLE(TABLA)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .c(c), .d(d), .yo(yo), .ys(ys), .z(z),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .mis_valid(mis_valid), .mis_got(mis_got)
  );

  verificador_tabla #(.SETTLE(1), .EXP_TABLE(TABLA)) u_dut1 (
    .clk(clk), .rst_n(rst_n_1), .start(start_1),
    .a(a1), .b(b1), .c(c1), .d(d1), .yo(yo1), .ys(ys1), .z(z1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
    .first_err_idx(first_err_idx1), .mis_valid(mis_valid1), .mis_got(mis_got1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_abcd"}, {a, b, c, d}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_first"}, first_err_idx, 0);
    chk({tag, "_misv"}, mis_valid, 0);
    chk({tag, "_misg"}, mis_got, 0);
  endtask

  // Runs one SETTLE=2 sweep on u_dut; again_at re-pulses start that many edges after E0.
  task automatic sweep(input bit do_start, input int again_at, input int exp_err,
                       input logic [3:0] exp_first, input bit exp_pass, input string tag);
    int         cyc, pulses, k;
    logic [3:0] kv;
    cyc    = 0;
    pulses = 0;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_busy_on"}, busy, 1);
      chk({tag, "_vec0"}, {a, b, c, d}, 0);
    end
    while (!done && cyc < 200) begin
      if (cyc == again_at) start = 1'b1;
      tick();
      start = 1'b0;
      cyc++;
      if (mis_valid) begin
        pulses++;
        k  = cyc / 3 - 1;
        kv = 4'(k);
        chk({tag, "_misgot"}, mis_got, {kv[3] & kv[2], kv[1] | kv[0], 1'b0});
      end
    end
    chk({tag, "_lat"}, cyc, 48);
    chk({tag, "_pass"}, pass, exp_pass);
    chk({tag, "_err"}, err_count, exp_err);
    chk({tag, "_first"}, first_err_idx, exp_first);
    chk({tag, "_pulses"}, pulses, exp_err);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_abcd_f"}, {a, b, c, d}, 4'hF);
    tick();
    tick();
    chk({tag, "_done_held"}, done, 1);
    chk({tag, "_err_held"}, err_count, exp_err);
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    start   = 1'b0;
    force_z = 1'b0;
    rst_n_1 = 1'b0;
    start_1 = 1'b0;
    repeat (2) tick();
    chk_reset_vals("rst");
    chk("rst1_busy", busy1, 0);
    chk("rst1_abcd", {a1, b1, c1, d1}, 0);
    rst_n   = 1'b1;
    rst_n_1 = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    sweep(1'b1, -1, 0, 4'd0, 1'b1, "ok");

    force_z = 1'b1;
    sweep(1'b1, -1, 8, 4'd1, 1'b0, "z0");

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_done", done, 0);
    chk("restart_err", err_count, 0);
    chk("restart_first", first_err_idx, 0);
    chk("restart_pass", pass, 0);
    chk("restart_busy", busy, 1);
    chk("restart_abcd", {a, b, c, d}, 0);
    chk("restart_misv", mis_valid, 0);
    sweep(1'b0, -1, 8, 4'd1, 1'b0, "z0_again");

    force_z = 1'b0;
    sweep(1'b1, 10, 0, 4'd0, 1'b1, "busy_start");

    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while ({a, b, c, d} != 4'd7 && n < 100) begin
      tick();
      n++;
    end
    chk("mid_vec7", {a, b, c, d}, 7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset_vals("mid_rst");
    tick();
    tick();
    chk("mid_rst_idle_busy", busy, 0);
    chk("mid_rst_idle_abcd", {a, b, c, d}, 0);

    start = 1'b1;
    rst_n = 1'b0;
    tick();
    start = 1'b0;
    rst_n = 1'b1;
    chk("rst_wins_busy", busy, 0);
    tick();
    chk("rst_wins_busy2", busy, 0);
    sweep(1'b1, -1, 0, 4'd0, 1'b1, "after_rst");

    start_1 = 1'b1;
    tick();
    start_1 = 1'b0;
    for (int j = 0; j < 32; j++) begin
      chk($sformatf("s1_vec_%0d", j), {a1, b1, c1, d1}, j / 2);
      if (j == 31) chk("s1_done_early", done1, 0);
      tick();
    end
    chk("s1_done", done1, 1);
    chk("s1_pass", pass1, 1);
    chk("s1_err", err_count1, 0);
    chk("s1_abcd_f", {a1, b1, c1, d1}, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
